// File: rtl/mbist_host_pkg.sv
// ============================================================================
// Module  : mbist_host_pkg
// Purpose : Shared constants and FSM state encoding for the MBIST host sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mbist_host_pkg;

    localparam int C_DATA_W      = 56;
    localparam int C_RUN_W       = 8;
    localparam int C_TIMEOUT_CYC = 4200;
    localparam int C_TO_W        = 13;

    // All-zero result word means the engine saw a clean memory
    localparam logic [C_DATA_W-1:0] C_EXP_SIG = '0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_BLANK  = 3'd2,
        S_WAIT   = 3'd3,
        S_CHECK  = 3'd4,
        S_FINISH = 3'd5
    } state_t;

endpackage : mbist_host_pkg

`default_nettype wire

// File: rtl/mbist_host_timer.sv
// ============================================================================
// Module  : mbist_host_timer
// Purpose : Clear/enable watchdog counter with a terminal-count flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mbist_host_timer #(
    parameter int TIMEOUT_CYC = 4200,
    parameter int TO_W        = 13
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [TO_W-1:0] C_TC = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] r_cnt;

    // Holds at the terminal value so the flag cannot wrap away
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != C_TC)) begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

    assign o_tc = (r_cnt == C_TC);

endmodule : mbist_host_timer

`default_nettype wire

// File: rtl/mbist_host_seq.sv
// ============================================================================
// Module  : mbist_host_seq
// Purpose : Host sequencer for top_mbist: start, wait, capture, compare, repeat.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mbist_host_seq
    import mbist_host_pkg::*;
#(
    parameter int                DATA_W      = C_DATA_W,
    parameter int                RUN_W       = C_RUN_W,
    parameter int                TIMEOUT_CYC = C_TIMEOUT_CYC,
    parameter int                TO_W        = C_TO_W,
    parameter logic [DATA_W-1:0] EXP_SIG     = DATA_W'(C_EXP_SIG)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              host_run,
    input  logic              host_abort,
    input  logic [RUN_W-1:0]  num_runs,
    output logic              MBIST_start,
    input  logic              MBIST_done,
    input  logic [DATA_W-1:0] mbist_data,
    output logic              busy,
    output logic              host_done,
    output logic              pass,
    output logic              timeout_err,
    output logic [RUN_W-1:0]  fail_cnt,
    output logic [DATA_W-1:0] first_fail_sig,
    output logic [DATA_W-1:0] last_sig
);

    state_t             r_state;
    logic [RUN_W-1:0]   r_runs;

    logic               w_tmr_clr;
    logic               w_tmr_en;
    logic               w_tmr_tc;
    logic               w_mismatch;
    logic               w_last_run;
    logic [RUN_W-1:0]   w_fail_next;

    assign w_mismatch  = (last_sig != EXP_SIG);
    assign w_last_run  = (r_runs == RUN_W'(1));
    assign w_fail_next = (w_mismatch && !(&fail_cnt)) ? fail_cnt + RUN_W'(1) : fail_cnt;

    // Timer restarts on every transition into START, so it reads 0 during the start pulse
    assign w_tmr_clr = !host_abort &&
                       (((r_state == S_IDLE) && host_run && (num_runs != '0)) ||
                        ((r_state == S_CHECK) && !w_last_run));
    assign w_tmr_en  = (r_state == S_START) || (r_state == S_BLANK) || (r_state == S_WAIT);

    mbist_host_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_timer (
        .clk   (clk),
        .rstn  (rstn),
        .i_clr (w_tmr_clr),
        .i_en  (w_tmr_en),
        .o_tc  (w_tmr_tc)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= S_IDLE;
            r_runs         <= '0;
            MBIST_start    <= 1'b0;
            busy           <= 1'b0;
            host_done      <= 1'b0;
            pass           <= 1'b0;
            timeout_err    <= 1'b0;
            fail_cnt       <= '0;
            first_fail_sig <= '0;
            last_sig       <= '0;
        end else begin
            MBIST_start <= 1'b0;
            host_done   <= 1'b0;
            if (host_abort) begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
                pass    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (host_run) begin
                            fail_cnt       <= '0;
                            first_fail_sig <= '0;
                            timeout_err    <= 1'b0;
                            if (num_runs != '0) begin
                                r_runs      <= num_runs;
                                busy        <= 1'b1;
                                pass        <= 1'b0;
                                MBIST_start <= 1'b1;
                                r_state     <= S_START;
                            end else begin
                                pass      <= 1'b1;
                                host_done <= 1'b1;
                                r_state   <= S_FINISH;
                            end
                        end
                    end
                    S_START: r_state <= S_BLANK;
                    // Engine still shows the previous done level during BLANK
                    S_BLANK: r_state <= S_WAIT;
                    S_WAIT: begin
                        if (MBIST_done) begin
                            last_sig <= mbist_data;
                            r_state  <= S_CHECK;
                        end else if (w_tmr_tc) begin
                            timeout_err <= 1'b1;
                            pass        <= 1'b0;
                            busy        <= 1'b0;
                            host_done   <= 1'b1;
                            r_state     <= S_FINISH;
                        end
                    end
                    S_CHECK: begin
                        fail_cnt <= w_fail_next;
                        if (w_mismatch && (fail_cnt == '0)) begin
                            first_fail_sig <= last_sig;
                        end
                        r_runs <= r_runs - RUN_W'(1);
                        if (w_last_run) begin
                            busy      <= 1'b0;
                            host_done <= 1'b1;
                            pass      <= (w_fail_next == '0) && !timeout_err;
                            r_state   <= S_FINISH;
                        end else begin
                            MBIST_start <= 1'b1;
                            r_state     <= S_START;
                        end
                    end
                    S_FINISH: r_state <= S_IDLE;
                    default:  r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule : mbist_host_seq

`default_nettype wire

// File: tb/tb_mbist_host_seq.sv
// ============================================================================
// Module  : tb_mbist_host_seq
// Purpose : Self-checking bench with an engine responder and session-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mbist_host_seq;

    localparam int DW = 56;
    localparam int RW = 8;
    localparam int TC = 4200;
    localparam logic [DW-1:0] EXP = '0;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          host_run = 1'b0;
    logic          host_abort = 1'b0;
    logic [RW-1:0] num_runs = '0;
    logic          MBIST_start;
    logic          MBIST_done = 1'b0;
    logic [DW-1:0] mbist_data = '0;
    logic          busy, host_done, pass, timeout_err;
    logic [RW-1:0] fail_cnt;
    logic [DW-1:0] first_fail_sig, last_sig;

    int n_chk = 0;
    int n_fail = 0;

    int cyc = 0, n_start = 0, n_done = 0;
    int last_start_cyc = -1, last_done_cyc = -1, to_rise_cyc = -1;
    int eng_base = 0, eng_rem = 0, eng_k = 0;
    logic          prev_to = 1'b0;
    logic [DW-1:0] eng_pend = '0;
    logic [DW-1:0] m_last = '0;
    int            eng_delay [0:255];
    logic [DW-1:0] eng_data  [0:255];

    mbist_host_seq dut (
        .clk            (clk),
        .rstn           (rstn),
        .host_run       (host_run),
        .host_abort     (host_abort),
        .num_runs       (num_runs),
        .MBIST_start    (MBIST_start),
        .MBIST_done     (MBIST_done),
        .mbist_data     (mbist_data),
        .busy           (busy),
        .host_done      (host_done),
        .pass           (pass),
        .timeout_err    (timeout_err),
        .fail_cnt       (fail_cnt),
        .first_fail_sig (first_fail_sig),
        .last_sig       (last_sig)
    );

    always #5 clk = ~clk;

    // Engine responder and event monitor; done rises eng_delay cycles after the start pulse
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (host_done) begin
            n_done        = n_done + 1;
            last_done_cyc = cyc;
        end
        if (timeout_err && !prev_to) to_rise_cyc = cyc;
        prev_to = timeout_err;
        if (MBIST_start) begin
            eng_k          = (n_start - eng_base) & 255;
            n_start        = n_start + 1;
            last_start_cyc = cyc;
            MBIST_done     = 1'b0;
            eng_rem        = eng_delay[eng_k];
            eng_pend       = eng_data[eng_k];
        end else if (eng_rem > 0) begin
            eng_rem = eng_rem - 1;
            if (eng_rem == 0) begin
                MBIST_done = 1'b1;
                mbist_data = eng_pend;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic rand_word(output logic [DW-1:0] w);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        w = ($urandom_range(0, 1) == 0) ? '0 : r[DW-1:0];
    endtask

    task automatic run_session(input string tag, input int num, input bit poke);
        int s0, d0, acc, budget, got, lat;
        int exp_starts, exp_fail;
        logic [DW-1:0] exp_first, exp_last;
        bit exp_to, exp_pass;
        exp_starts = 0; exp_fail = 0; exp_first = '0; exp_last = m_last; exp_to = 0; budget = 20;
        for (int k = 0; k < num; k++) begin
            exp_starts++;
            if (eng_delay[k] >= TC) begin
                exp_to = 1;
                budget += TC + 6;
                break;
            end
            budget += eng_delay[k] + 6;
            exp_last = eng_data[k];
            if (eng_data[k] != EXP) begin
                if (exp_fail == 0) exp_first = eng_data[k];
                if (exp_fail < 255) exp_fail++;
            end
        end
        exp_pass = (exp_fail == 0) && !exp_to;

        s0 = n_start; d0 = n_done; eng_base = n_start; acc = cyc;
        host_run = 1'b1; num_runs = RW'(num);
        tick(1);
        host_run = 1'b0;
        got = (num == 0) ? last_done_cyc : last_start_cyc;
        n_chk++;
        if (got !== acc + 1) begin
            n_fail++; $display("FAIL %s accept_latency: got cycle %0d want %0d", tag, got, acc + 1);
        end
        if (poke) begin
            tick(2);
            host_run = 1'b1; num_runs = RW'(9);
            tick(1);
            host_run = 1'b0;
        end
        for (int i = 0; i < budget && n_done == d0; i++) tick(1);
        tick(20);

        n_chk++;
        if (n_done - d0 !== 1) begin
            n_fail++; $display("FAIL %s host_done_count: got %0d want 1", tag, n_done - d0);
        end
        n_chk++;
        if (n_start - s0 !== exp_starts) begin
            n_fail++; $display("FAIL %s start_pulses: got %0d want %0d", tag, n_start - s0, exp_starts);
        end
        if (num > 0) begin
            lat = exp_to ? TC : eng_delay[exp_starts-1] + 2;
            n_chk++;
            if (last_done_cyc - last_start_cyc !== lat) begin
                n_fail++; $display("FAIL %s done_latency: got %0d want %0d", tag, last_done_cyc - last_start_cyc, lat);
            end
        end
        if (exp_to) begin
            n_chk++;
            if (to_rise_cyc - last_start_cyc !== TC) begin
                n_fail++; $display("FAIL %s timeout_latency: got %0d want %0d", tag, to_rise_cyc - last_start_cyc, TC);
            end
        end
        n_chk++;
        if (fail_cnt !== RW'(exp_fail)) begin
            n_fail++; $display("FAIL %s fail_cnt: got %0d want %0d", tag, fail_cnt, exp_fail);
        end
        n_chk++;
        if (first_fail_sig !== exp_first) begin
            n_fail++; $display("FAIL %s first_fail_sig: got %h want %h", tag, first_fail_sig, exp_first);
        end
        n_chk++;
        if (last_sig !== exp_last) begin
            n_fail++; $display("FAIL %s last_sig: got %h want %h", tag, last_sig, exp_last);
        end
        n_chk++;
        if (pass !== exp_pass) begin
            n_fail++; $display("FAIL %s pass: got %b want %b", tag, pass, exp_pass);
        end
        n_chk++;
        if (timeout_err !== exp_to) begin
            n_fail++; $display("FAIL %s timeout_err: got %b want %b", tag, timeout_err, exp_to);
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL %s busy_after: got %b want 0", tag, busy);
        end
        m_last = exp_last;
    endtask

    task automatic test_reset();
        tick(3);
        n_chk++;
        if ({busy, MBIST_start, host_done, pass, timeout_err, fail_cnt, first_fail_sig, last_sig} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got busy=%b start=%b done=%b pass=%b to=%b fc=%0d", busy, MBIST_start, host_done, pass, timeout_err, fail_cnt);
        end
        rstn = 1'b1;
        tick(5);
        n_chk++;
        if (n_start !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: got starts=%0d busy=%b want 0 0", n_start, busy);
        end
    endtask

    task automatic test_single_clean();
        eng_delay[0] = 4100; eng_data[0] = '0;
        run_session("single_clean", 1, 1'b0);
    endtask

    task automatic test_three_runs();
        eng_delay[0] = 10; eng_data[0] = '0;
        eng_delay[1] = 7;  eng_data[1] = 56'hDEAD_BEEF;
        eng_delay[2] = 12; eng_data[2] = 56'h1;
        run_session("three_runs", 3, 1'b0);
    endtask

    task automatic test_timeout();
        eng_delay[0] = 1000000; eng_data[0] = '0;
        eng_delay[1] = 5;       eng_data[1] = '0;
        run_session("timeout", 3, 1'b0);
        eng_rem = 0;
    endtask

    task automatic test_done_boundary();
        eng_delay[0] = TC - 1; eng_data[0] = 56'h55;
        run_session("done_wins", 1, 1'b0);
    endtask

    task automatic test_abort();
        int s0, d0;
        for (int k = 0; k < 4; k++) begin eng_delay[k] = 20; eng_data[k] = '0; end
        eng_data[0] = 56'h5;
        s0 = n_start; d0 = n_done; eng_base = n_start;
        host_run = 1'b1; num_runs = RW'(4);
        tick(1);
        host_run = 1'b0;
        for (int i = 0; i < 200 && n_start - s0 < 2; i++) tick(1);
        tick(5);
        host_abort = 1'b1;
        tick(1);
        host_abort = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || MBIST_start !== 1'b0 || pass !== 1'b0) begin
            n_fail++; $display("FAIL abort_outputs: got busy=%b start=%b pass=%b want 0 0 0", busy, MBIST_start, pass);
        end
        n_chk++;
        if (fail_cnt !== RW'(1) || first_fail_sig !== 56'h5 || last_sig !== 56'h5) begin
            n_fail++; $display("FAIL abort_retain: got fc=%0d first=%h last=%h want 1 5 5", fail_cnt, first_fail_sig, last_sig);
        end
        tick(100);
        n_chk++;
        if (n_done !== d0 || n_start - s0 !== 2) begin
            n_fail++; $display("FAIL abort_quiet: got done=%0d starts=%0d want 0 2", n_done - d0, n_start - s0);
        end
        m_last = 56'h5;
    endtask

    task automatic test_zero_and_busy();
        run_session("zero_runs", 0, 1'b0);
        eng_delay[0] = 9; eng_data[0] = '0;
        eng_delay[1] = 6; eng_data[1] = 56'hABC;
        run_session("run_while_busy", 2, 1'b1);
    endtask

    task automatic test_reset_mid_wait();
        int s0, d0;
        eng_delay[0] = 500; eng_data[0] = '0;
        s0 = n_start; d0 = n_done; eng_base = n_start;
        host_run = 1'b1; num_runs = RW'(2);
        tick(1);
        host_run = 1'b0;
        tick(20);
        rstn = 1'b0;
        #2;
        n_chk++;
        if ({busy, MBIST_start, host_done, pass, timeout_err, fail_cnt, first_fail_sig, last_sig} !== '0) begin
            n_fail++; $display("FAIL reset_mid_wait: got busy=%b fc=%0d last=%h want all 0", busy, fail_cnt, last_sig);
        end
        tick(1);
        rstn = 1'b1;
        tick(700);
        n_chk++;
        if (n_start - s0 !== 1 || n_done !== d0) begin
            n_fail++; $display("FAIL reset_quiet: got starts=%0d done=%0d want 1 0", n_start - s0, n_done - d0);
        end
        m_last = '0;
    endtask

    task automatic test_random();
        int num;
        for (int s = 0; s < 6; s++) begin
            num = $urandom_range(1, 5);
            for (int k = 0; k < num; k++) begin
                eng_delay[k] = $urandom_range(2, 60);
                rand_word(eng_data[k]);
            end
            run_session($sformatf("random%0d", s), num, s[0]);
        end
    endtask

    task automatic test_max_runs();
        for (int k = 0; k < 255; k++) begin
            eng_delay[k] = 2;
            eng_data[k]  = DW'(k + 1);
        end
        run_session("max_runs", 255, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_clean();
        test_three_runs();
        test_timeout();
        test_done_boundary();
        test_abort();
        test_zero_and_busy();
        test_reset_mid_wait();
        test_random();
        test_max_runs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_mbist_host_seq

`default_nettype wire
